// File: rtl/timer_pkg.sv
// Shared constants for cascaded digit counters: default geometry and the
// decimal / sexagesimal digit maxima used for clock-style counts.
package timer_pkg;

  localparam int unsigned DIGIT_W_DEF    = 4;
  localparam int unsigned NUM_DIGITS_DEF = 4;
  localparam int unsigned DEC_MAX        = 9;
  localparam int unsigned SEX_MAX        = 5;

endpackage

// File: rtl/digit_cell.sv
// One counter digit: steps up or down when enabled, wraps between 0 and its
// maximum, optionally presets to a clamped value, and reports at-max / at-zero.
module digit_cell
  import timer_pkg::*;
#(
  parameter int unsigned DIGIT_W = DIGIT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step_en,
  input  logic               dir_up,
  input  logic               load,
  input  logic [DIGIT_W-1:0] max,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] value,
  output logic [DIGIT_W-1:0] value_nxt_c,
  output logic               at_max_c,
  output logic               at_zero_c
);

  // A value left above a lowered maximum still counts as full for carries.
  assign at_max_c  = (value >= max);
  assign at_zero_c = (value == '0);

  always_comb begin
    value_nxt_c = value;
    if (load) begin
      value_nxt_c = (load_val > max) ? max : load_val;
    end else if (step_en) begin
      if (dir_up) begin
        value_nxt_c = at_max_c ? '0 : value + DIGIT_W'(1);
      end else begin
        value_nxt_c = at_zero_c ? max : value - DIGIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else begin
      value <= value_nxt_c;
    end
  end

endmodule

// File: rtl/multi_digit_counter.sv
// Cascaded up/down digit counter with per-digit maxima, wrap or saturate at
// the ends. Define MULTI_DIGIT_COUNTER_LOAD_EN to add a synchronous preset.
module multi_digit_counter
  import timer_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int unsigned DIGIT_W    = DIGIT_W_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_cnt_up,
  input  logic                          i_cnt_dwn,
  input  logic                          i_wrap_en,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] i_max_count,
`ifdef MULTI_DIGIT_COUNTER_LOAD_EN
  input  logic                          i_load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] i_load_val,
`endif
  output logic [NUM_DIGITS*DIGIT_W-1:0] o_digit_vals,
  output logic                          o_zero,
  output logic                          o_at_max,
  output logic                          o_wrap
);

  localparam int unsigned CNT_W = NUM_DIGITS * DIGIT_W;

  logic                  load;
  logic [CNT_W-1:0]      load_val;
  logic [NUM_DIGITS-1:0] at_max;
  logic [NUM_DIGITS-1:0] at_zero;
  logic [NUM_DIGITS-1:0] step_en;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  do_up;
  logic                  wrap_evt;
  logic                  zero_q;
  logic                  at_max_q;
  logic                  wrap_q;
  logic                  live_q;

`ifdef MULTI_DIGIT_COUNTER_LOAD_EN
  assign load     = i_load;
  assign load_val = i_load_val;
`else
  assign load     = 1'b0;
  assign load_val = '0;
`endif

  // Carry/borrow ripple: a digit steps only when every lower digit is full/empty.
  always_comb begin
    logic run_up;
    logic run_dn;
    logic do_dn;
    logic boundary;
    do_up    = i_cnt_up & ~i_cnt_dwn;
    do_dn    = i_cnt_dwn & ~i_cnt_up;
    run_up   = 1'b1;
    run_dn   = 1'b1;
    step_en  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      step_en[k] = (do_up & run_up) | (do_dn & run_dn);
      run_up     = run_up & at_max[k];
      run_dn     = run_dn & at_zero[k];
    end
    boundary = (do_up & run_up) | (do_dn & run_dn);
    if (load || (boundary && !i_wrap_en)) begin
      step_en = '0;
    end
    wrap_evt = boundary & i_wrap_en & ~load;
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    digit_cell #(
      .DIGIT_W (DIGIT_W)
    ) u_digit (
      .clk         (i_clk),
      .rst_n       (i_reset_n),
      .step_en     (step_en[k]),
      .dir_up      (do_up),
      .load        (load),
      .max         (i_max_count[k*DIGIT_W +: DIGIT_W]),
      .load_val    (load_val[k*DIGIT_W +: DIGIT_W]),
      .value       (o_digit_vals[k*DIGIT_W +: DIGIT_W]),
      .value_nxt_c (cnt_nxt[k*DIGIT_W +: DIGIT_W]),
      .at_max_c    (at_max[k]),
      .at_zero_c   (at_zero[k])
    );
  end

  // Flags track the post-edge count so they move together with the digits.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      zero_q   <= 1'b1;
      at_max_q <= 1'b0;
      wrap_q   <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      zero_q   <= (cnt_nxt == '0);
      at_max_q <= (cnt_nxt == i_max_count);
      wrap_q   <= wrap_evt;
      live_q   <= 1'b1;
    end
  end

  // Until the first edge after reset the count is all-zero, so at-max means all maxima are 0.
  assign o_zero   = zero_q;
  assign o_wrap   = wrap_q;
  assign o_at_max = live_q ? at_max_q : (i_max_count == '0);

endmodule
